// File: rtl/coreaxi4dmacontroller_channel_dispatcher_if.sv
// Transfer-command bus between the channel dispatcher (master) and the AXI
// transfer engine (slave): valid/ready command plus done/err completion.
interface coreaxi4dmacontroller_channel_dispatcher_if #(
  parameter int CH_ID_WIDTH = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int CNT_WIDTH   = 23
);
  logic                   xfer_valid;
  logic                   xfer_ready;
  logic [CH_ID_WIDTH-1:0] xfer_ch_id;
  logic [ADDR_WIDTH-1:0]  xfer_src_addr;
  logic [ADDR_WIDTH-1:0]  xfer_dst_addr;
  logic [CNT_WIDTH-1:0]   xfer_byte_cnt;
  logic                   xfer_done;
  logic                   xfer_err;

  modport master (
    output xfer_valid, xfer_ch_id, xfer_src_addr, xfer_dst_addr, xfer_byte_cnt,
    input  xfer_ready, xfer_done, xfer_err
  );

  modport slave (
    input  xfer_valid, xfer_ch_id, xfer_src_addr, xfer_dst_addr, xfer_byte_cnt,
    output xfer_ready, xfer_done, xfer_err
  );
endinterface

// File: rtl/coreaxi4dmacontroller_channel_dispatcher.sv
// Latches the arbiter's winning descriptor, issues it to the transfer engine and
// acknowledges the owning channel. Optional watchdog: COREAXI4DMA_DISPATCH_WATCHDOG_EN.
module coreaxi4dmacontroller_channel_dispatcher #(
  parameter int NUM_CHANNELS = 4,
  parameter int CH_ID_WIDTH  = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int CNT_WIDTH    = 23,
  parameter int WDOG_LIMIT   = 1023
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic [NUM_CHANNELS-1:0]            chan_req_i,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] chan_src_addr_i,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] chan_dst_addr_i,
  input  logic [NUM_CHANNELS*CNT_WIDTH-1:0]  chan_byte_cnt_i,
  input  logic [NUM_CHANNELS-1:0]            arb_grant_i,
  output logic                               arb_update_o,
  coreaxi4dmacontroller_channel_dispatcher_if.master xfer_if,
  output logic [NUM_CHANNELS-1:0]            chan_ack_o,
  output logic                               chan_err_o,
  output logic                               busy_o
);

  if (CH_ID_WIDTH != $clog2(NUM_CHANNELS) || WDOG_LIMIT < 1) begin : g_param_check
    $error("coreaxi4dmacontroller_channel_dispatcher: inconsistent parameters");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_DONE} state_e;

  localparam logic [NUM_CHANNELS-1:0] ONE_HOT_0 = NUM_CHANNELS'(1);

  state_e                  state_q;
  logic [CH_ID_WIDTH-1:0]  ch_id_q;
  logic [ADDR_WIDTH-1:0]   src_q;
  logic [ADDR_WIDTH-1:0]   dst_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic                    xfer_valid_q;
  logic [NUM_CHANNELS-1:0] chan_ack_q;
  logic                    chan_err_q;

  logic [NUM_CHANNELS-1:0] eff;
  logic [CH_ID_WIDTH-1:0]  sel_id;
  logic [ADDR_WIDTH-1:0]   sel_src;
  logic [ADDR_WIDTH-1:0]   sel_dst;
  logic [CNT_WIDTH-1:0]    sel_cnt;
  logic                    capture;

`ifdef COREAXI4DMA_DISPATCH_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);
  logic [WDOG_W-1:0] wdog_q;
`endif

  // Lowest set bit of the qualified grant wins, guarding against a multi-hot grant.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    eff     = arb_grant_i & chan_req_i;
    sel_id  = '0;
    sel_src = '0;
    sel_dst = '0;
    sel_cnt = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (eff[i]) begin
        sel_id  = CH_ID_WIDTH'(i);
        sel_src = chan_src_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_dst = chan_dst_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_cnt = chan_byte_cnt_i[i*CNT_WIDTH +: CNT_WIDTH];
      end
    end
  end

  assign capture = (state_q == S_IDLE) && (|eff) && !reset_i;

  // NOTE: state is written only with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      ch_id_q      <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      cnt_q        <= '0;
      xfer_valid_q <= 1'b0;
      chan_ack_q   <= '0;
      chan_err_q   <= 1'b0;
`ifdef COREAXI4DMA_DISPATCH_WATCHDOG_EN
      wdog_q       <= '0;
`endif
    end else begin
      chan_ack_q <= '0;
      chan_err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (capture) begin
            ch_id_q <= sel_id;
            src_q   <= sel_src;
            dst_q   <= sel_dst;
            cnt_q   <= sel_cnt;
            if (sel_cnt == '0) begin
              state_q    <= S_DONE;
              chan_ack_q <= ONE_HOT_0 << sel_id;
            end else begin
              state_q      <= S_ISSUE;
              xfer_valid_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (xfer_if.xfer_ready) begin
            state_q      <= S_BUSY;
            xfer_valid_q <= 1'b0;
`ifdef COREAXI4DMA_DISPATCH_WATCHDOG_EN
            wdog_q       <= '0;
`endif
          end
        end
        S_BUSY: begin
          // A real completion takes priority over a coincident watchdog expiry.
          if (xfer_if.xfer_done) begin
            state_q    <= S_DONE;
            chan_ack_q <= ONE_HOT_0 << ch_id_q;
            chan_err_q <= xfer_if.xfer_err;
          end
`ifdef COREAXI4DMA_DISPATCH_WATCHDOG_EN
          else if (wdog_q == WDOG_W'(WDOG_LIMIT - 1)) begin
            state_q    <= S_DONE;
            chan_ack_q <= ONE_HOT_0 << ch_id_q;
            chan_err_q <= 1'b1;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
`endif
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign arb_update_o          = capture;
  assign xfer_if.xfer_valid    = xfer_valid_q;
  assign xfer_if.xfer_ch_id    = ch_id_q;
  assign xfer_if.xfer_src_addr = src_q;
  assign xfer_if.xfer_dst_addr = dst_q;
  assign xfer_if.xfer_byte_cnt = cnt_q;
  assign chan_ack_o            = chan_ack_q;
  assign chan_err_o            = chan_err_q;
  assign busy_o                = (state_q != S_IDLE);

endmodule

// File: tb/tb_coreaxi4dmacontroller_channel_dispatcher.sv
// Directed bench for the channel dispatcher; the watchdog steps run only when
// COREAXI4DMA_DISPATCH_WATCHDOG_EN is defined (limit overridden to 16).
module tb_coreaxi4dmacontroller_channel_dispatcher;
  localparam int NCH  = 4;
  localparam int IDW  = 2;
  localparam int AW   = 32;
  localparam int CW   = 23;
  localparam int WDOG = 16;

  logic                clock_i = 1'b0;
  logic                reset_i;
  logic [NCH-1:0]      chan_req_i;
  logic [NCH*AW-1:0]   chan_src_addr_i;
  logic [NCH*AW-1:0]   chan_dst_addr_i;
  logic [NCH*CW-1:0]   chan_byte_cnt_i;
  logic [NCH-1:0]      arb_grant_i;
  logic                arb_update_o;
  logic [NCH-1:0]      chan_ack_o;
  logic                chan_err_o;
  logic                busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  coreaxi4dmacontroller_channel_dispatcher_if #(
    .CH_ID_WIDTH(IDW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) xfer_if ();

  coreaxi4dmacontroller_channel_dispatcher #(
    .NUM_CHANNELS(NCH), .CH_ID_WIDTH(IDW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW),
    .WDOG_LIMIT(WDOG)
  ) dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .chan_req_i     (chan_req_i),
    .chan_src_addr_i(chan_src_addr_i),
    .chan_dst_addr_i(chan_dst_addr_i),
    .chan_byte_cnt_i(chan_byte_cnt_i),
    .arb_grant_i    (arb_grant_i),
    .arb_update_o   (arb_update_o),
    .xfer_if        (xfer_if.master),
    .chan_ack_o     (chan_ack_o),
    .chan_err_o     (chan_err_o),
    .busy_o         (busy_o)
  );

  always #5 clock_i = ~clock_i;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one rising edge, then settle just after it.
  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  initial begin
    reset_i               = 1'b1;
    chan_req_i            = '0;
    arb_grant_i           = '0;
    xfer_if.xfer_ready    = 1'b0;
    xfer_if.xfer_done     = 1'b0;
    xfer_if.xfer_err      = 1'b0;
    chan_src_addr_i = {32'h1000_0300, 32'h1000_0200, 32'h1000_0100, 32'h1000_0000};
    chan_dst_addr_i = {32'h2000_0300, 32'h2000_0200, 32'h2000_0100, 32'h2000_0000};
    chan_byte_cnt_i = {23'd128, 23'd0, 23'd64, 23'd16};

    tick();
    tick();
    check("rst_busy",  busy_o, 0);
    check("rst_valid", xfer_if.xfer_valid, 0);
    check("rst_ack",   chan_ack_o, 0);
    check("rst_err",   chan_err_o, 0);
    check("rst_upd",   arb_update_o, 0);
    check("rst_chid",  xfer_if.xfer_ch_id, 0);
    check("rst_src",   xfer_if.xfer_src_addr, 0);
    check("rst_cnt",   xfer_if.xfer_byte_cnt, 0);
    reset_i = 1'b0;
    tick();

    // Single request on channel 1, done on the third BUSY cycle.
    chan_req_i  = 4'b0010;
    arb_grant_i = 4'b0010;
    #1;
    check("t1_upd_capture", arb_update_o, 1);
    tick();
    check("t1_valid", xfer_if.xfer_valid, 1);
    check("t1_chid",  xfer_if.xfer_ch_id, 1);
    check("t1_src",   xfer_if.xfer_src_addr, 32'h1000_0100);
    check("t1_dst",   xfer_if.xfer_dst_addr, 32'h2000_0100);
    check("t1_cnt",   xfer_if.xfer_byte_cnt, 64);
    check("t1_upd_issue", arb_update_o, 0);
    check("t1_busy",  busy_o, 1);
    arb_grant_i        = '0;
    xfer_if.xfer_ready = 1'b1;
    tick();
    check("t1_valid_drop", xfer_if.xfer_valid, 0);
    xfer_if.xfer_ready = 1'b0;
    tick();
    tick();
    check("t1_no_early_ack", chan_ack_o, 0);
    xfer_if.xfer_done = 1'b1;
    tick();
    check("t1_ack", chan_ack_o, 4'b0010);
    check("t1_err", chan_err_o, 0);
    xfer_if.xfer_done = 1'b0;
    chan_req_i        = '0;
    tick();
    check("t1_ack_pulse", chan_ack_o, 0);
    check("t1_idle", busy_o, 0);

    // Backpressure on channel 3, then an error completion.
    chan_req_i  = 4'b1000;
    arb_grant_i = 4'b1000;
    tick();
    arb_grant_i = '0;
    for (int i = 0; i < 10; i++) begin
      check("t2_bp_valid", xfer_if.xfer_valid, 1);
      check("t2_bp_fields", {xfer_if.xfer_ch_id, xfer_if.xfer_src_addr, xfer_if.xfer_byte_cnt[22:0]},
            {2'd3, 32'h1000_0300, 23'd128});
      tick();
    end
    check("t2_bp_dst", xfer_if.xfer_dst_addr, 32'h2000_0300);
    xfer_if.xfer_ready = 1'b1;
    tick();
    check("t2_hs_valid", xfer_if.xfer_valid, 0);
    check("t2_hs_busy",  busy_o, 1);
    xfer_if.xfer_ready = 1'b0;
    xfer_if.xfer_done  = 1'b1;
    xfer_if.xfer_err   = 1'b1;
    tick();
    check("t2_ack", chan_ack_o, 4'b1000);
    check("t2_err", chan_err_o, 1);
    xfer_if.xfer_done = 1'b0;
    xfer_if.xfer_err  = 1'b0;
    chan_req_i        = '0;
    tick();
    check("t2_err_pulse", chan_err_o, 0);

    // Zero-length descriptor on channel 2.
    chan_req_i  = 4'b0100;
    arb_grant_i = 4'b0100;
    #1;
    check("t3_upd", arb_update_o, 1);
    tick();
    check("t3_ack",   chan_ack_o, 4'b0100);
    check("t3_err",   chan_err_o, 0);
    check("t3_valid", xfer_if.xfer_valid, 0);
    chan_req_i  = '0;
    arb_grant_i = '0;
    tick();
    check("t3_idle", busy_o, 0);
    check("t3_ack_pulse", chan_ack_o, 0);

    // Grant without request: no capture.
    arb_grant_i = 4'b0001;
    #1;
    check("t4_no_upd", arb_update_o, 0);
    tick();
    check("t4_no_busy", busy_o, 0);
    check("t4_no_valid", xfer_if.xfer_valid, 0);

    // Multi-hot grant: lowest qualified bit (channel 1) wins.
    chan_req_i  = 4'b0110;
    arb_grant_i = 4'b0110;
    #1;
    check("t5_upd", arb_update_o, 1);
    tick();
    check("t5_chid", xfer_if.xfer_ch_id, 1);
    check("t5_src",  xfer_if.xfer_src_addr, 32'h1000_0100);
    arb_grant_i        = '0;
    xfer_if.xfer_ready = 1'b1;
    tick();
    xfer_if.xfer_ready = 1'b0;
    check("t5_busy", busy_o, 1);

    // Reset while BUSY, then a stray done.
    reset_i = 1'b1;
    tick();
    check("t6_busy",  busy_o, 0);
    check("t6_valid", xfer_if.xfer_valid, 0);
    check("t6_ack",   chan_ack_o, 0);
    check("t6_chid",  xfer_if.xfer_ch_id, 0);
    check("t6_src",   xfer_if.xfer_src_addr, 0);
    check("t6_cnt",   xfer_if.xfer_byte_cnt, 0);
    reset_i           = 1'b0;
    chan_req_i        = '0;
    xfer_if.xfer_done = 1'b1;
    tick();
    xfer_if.xfer_done = 1'b0;
    check("t6_stray_ack",  chan_ack_o, 0);
    check("t6_stray_busy", busy_o, 0);
    tick();
    check("t6_stray_ack2", chan_ack_o, 0);

`ifdef COREAXI4DMA_DISPATCH_WATCHDOG_EN
    // Watchdog expiry after 16 BUSY cycles without done.
    chan_req_i  = 4'b0001;
    arb_grant_i = 4'b0001;
    tick();
    arb_grant_i        = '0;
    xfer_if.xfer_ready = 1'b1;
    tick();
    xfer_if.xfer_ready = 1'b0;
    for (int i = 0; i < WDOG - 1; i++) begin
      tick();
      check("wd_waiting", {busy_o, chan_ack_o}, {1'b1, 4'b0000});
    end
    tick();
    check("wd_ack", chan_ack_o, 4'b0001);
    check("wd_err", chan_err_o, 1);
    tick();

    // Done coinciding with the limit: done wins, err follows xfer_err.
    arb_grant_i = 4'b0001;
    tick();
    arb_grant_i        = '0;
    xfer_if.xfer_ready = 1'b1;
    tick();
    xfer_if.xfer_ready = 1'b0;
    for (int i = 0; i < WDOG - 1; i++) tick();
    check("wd2_still_busy", chan_ack_o, 0);
    xfer_if.xfer_done = 1'b1;
    xfer_if.xfer_err  = 1'b0;
    tick();
    xfer_if.xfer_done = 1'b0;
    check("wd2_ack", chan_ack_o, 4'b0001);
    check("wd2_err", chan_err_o, 0);
    chan_req_i = '0;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/coreaxi4dmacontroller_channel_dispatcher.md
# coreaxi4dmacontroller_channel_dispatcher

Downstream consumer of the DMA controller's round-robin channel arbiter. Takes the arbiter's combinational one-hot grant, latches the winning channel's descriptor fields, and pulses the arbiter's priority-update strobe. Hands the transfer to the AXI transfer engine over a valid/ready handshake, then returns a one-cycle completion acknowledge to the owning channel.

## Interface
- NUM_CHANNELS, 4, channel count; matches the arbiter width
- CH_ID_WIDTH, 2, width of the encoded channel index; must equal ceil(log2(NUM_CHANNELS))
- ADDR_WIDTH, 32, descriptor source/destination address width
- CNT_WIDTH, 23, descriptor byte-count width
- WDOG_LIMIT, 1023, watchdog abort threshold in cycles; used only when the watchdog is compiled in
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- chan_req  in  NUM_CHANNELS  per-channel level request; held until that channel's chan_ack
- chan_src_addr  in  NUM_CHANNELS*ADDR_WIDTH  flattened per-channel source address; channel i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- chan_dst_addr  in  NUM_CHANNELS*ADDR_WIDTH  flattened per-channel destination address
- chan_byte_cnt  in  NUM_CHANNELS*CNT_WIDTH  flattened per-channel byte count
- arb_grant  in  NUM_CHANNELS  one-hot grant from the arbiter, combinational
- arb_update  out  1  priority-update strobe to the arbiter
- xfer_valid  out  1  transfer command valid
- xfer_ready  in  1  transfer engine accepts the command
- xfer_ch_id  out  CH_ID_WIDTH  channel index of the command
- xfer_src_addr, xfer_dst_addr  out  ADDR_WIDTH  latched addresses
- xfer_byte_cnt  out  CNT_WIDTH  latched byte count
- xfer_done  in  1  one-cycle completion pulse from the engine
- xfer_err  in  1  error qualifier, valid with xfer_done
- chan_ack  out  NUM_CHANNELS  one-hot, one-cycle completion pulse
- chan_err  out  1  error flag, valid with chan_ack
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, BUSY, DONE.
- **IDLE**
  - Compute eff = arb_grant & chan_req.
  - If eff is nonzero, select the lowest set bit of eff. This is a defensive measure against a multi-hot grant.
  - On the selection edge: register ch_id and the selected channel's src, dst and byte count.
  - arb_update = 1 combinationally in the same cycle.
  - If the latched byte count is 0, go to DONE with err = 0 and issue no command. Otherwise go to ISSUE.
- **ISSUE**
  - xfer_valid = 1.
  - All xfer_* outputs are stable until the handshake.
  - On xfer_valid & xfer_ready, go to BUSY.
- **BUSY**
  - Wait for xfer_done.
  - On xfer_done, latch err = xfer_err and go to DONE.
- **DONE**
  - chan_ack[ch_id] = 1 and chan_err = err for exactly one cycle.
  - Go to IDLE.
- arb_update is high only in IDLE on a capture cycle. It is never asserted when eff = 0.
- A chan_req deassertion after capture is ignored; the transfer completes and is acknowledged.
- xfer_done outside BUSY is ignored.
- Reset values:
  - state = IDLE.
  - xfer_valid, arb_update, chan_ack, chan_err and busy = 0.
  - xfer_ch_id, xfer_src_addr, xfer_dst_addr and xfer_byte_cnt = 0.
  - Watchdog counter = 0.
- Reset mid-transfer returns to IDLE on the next edge. xfer_valid drops and no ack is issued. Engine cleanup is the engine's responsibility.

## Timing
- Capture edge to xfer_valid high: 1 cycle.
- Handshake edge to BUSY: 1 cycle. xfer_done is sampled from the first BUSY cycle.
- xfer_done edge to chan_ack: 1 cycle. IDLE follows the next cycle.
- Minimum spacing between captures: 4 cycles (IDLE, ISSUE with ready=1, BUSY with done=1, DONE).
- Zero-length descriptor: capture to chan_ack is 1 cycle; capture-to-capture is 2 cycles.
- xfer_valid, once high, is never deasserted before xfer_ready, except on reset.
- arb_update, chan_ack and the xfer_* outputs contain no combinational path from xfer_ready or xfer_done.

## Configuration
- COREAXI4DMA_DISPATCH_WATCHDOG_EN, when defined:
  - A counter increments every BUSY cycle and clears on entry to BUSY.
  - When it reaches WDOG_LIMIT without xfer_done, the FSM goes to DONE with err = 1.
  - If xfer_done and the limit coincide in the same cycle, xfer_done wins and err = xfer_err.
- When undefined: no counter is built and BUSY waits indefinitely for xfer_done.

## Test plan
- Single request: chan_req=0010, grant=0010, byte_cnt=64, ready=1, done 3 cycles after the handshake. Required response:
  - arb_update for 1 cycle.
  - xfer_ch_id=1 with the channel 1 fields.
  - chan_ack=0010, chan_err=0.
  - busy low again after DONE.
- Backpressure: hold xfer_ready=0 for 10 cycles. Required response: xfer_valid stays high and all xfer_* outputs stay constant. The handshake completes on the first cycle with ready=1.
- Zero length: channel 2 with byte_cnt=0. Required response: xfer_valid is never asserted, and chan_ack=0100 with chan_err=0 one cycle after capture.
- Error and illegal grant:
  - xfer_err=1 with done gives chan_ack with chan_err=1.
  - chan_req=0000 with grant=0001 gives no capture and no arb_update.
  - grant=0110 with req=0110 selects channel 1.
- Reset in BUSY: assert reset for 1 cycle. Required response:
  - All outputs return to reset values on the next edge.
  - A subsequent stray xfer_done produces no chan_ack.
- Watchdog (macro on, WDOG_LIMIT=16): no xfer_done after the handshake. Required response: chan_ack with chan_err=1 after 16 BUSY cycles. Repeating with done on cycle 16 gives chan_err=xfer_err.
